// File: rtl/tpu_pkg.sv
// ----------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the systolic array datapath and its neighbours.
//   DATA_W : lane width, Q8.8 signed fixed point
//   row_t  : one deskewed result row, two lanes packed {lane1, lane2}
//   relu   : clamps a negative lane to zero, used when SYSTOLIC_DRAIN_RELU_EN
//            is defined
// ----------------------------------------------------------------------------
package tpu_pkg;

    localparam int DATA_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] lane1;
        logic [DATA_W-1:0] lane2;
    } row_t;

    // A set sign bit means the Q8.8 value is negative, so the lane goes to zero.
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? {DATA_W{1'b0}} : x;
    endfunction

endpackage

// File: rtl/systolic_drain_if.sv
// ----------------------------------------------------------------------------
// systolic_drain_if
// Bundles the array-side column buses, the consumer-side row handshake and
// the drain status flags.
//   in_data_1/in_valid_1 : column-1 psum and valid from the array
//   in_data_2/in_valid_2 : column-2 psum and valid, one cycle behind column 1
//   out_data_1/2         : head row lanes
//   out_valid/out_ready  : head row handshake toward the next stage
//   count/full/empty     : FIFO occupancy
//   overflow/skew_err    : sticky error flags
// Modports: master = array plus consumer side, slave = the drain itself.
// ----------------------------------------------------------------------------
interface systolic_drain_if
    import tpu_pkg::*;
#(
    parameter int DEPTH = 4
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] in_data_1;
    logic              in_valid_1;
    logic [DATA_W-1:0] in_data_2;
    logic              in_valid_2;
    logic [DATA_W-1:0] out_data_1;
    logic [DATA_W-1:0] out_data_2;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              skew_err;

    modport master (
        output in_data_1, in_valid_1, in_data_2, in_valid_2, out_ready,
        input  out_data_1, out_data_2, out_valid, count, full, empty,
               overflow, skew_err
    );

    modport slave (
        input  in_data_1, in_valid_1, in_data_2, in_valid_2, out_ready,
        output out_data_1, out_data_2, out_valid, count, full, empty,
               overflow, skew_err
    );

endinterface

// File: rtl/systolic_drain_fifo.sv
// ----------------------------------------------------------------------------
// drain_fifo
// Row FIFO of DEPTH entries (power of two, >= 2) for deskewed result rows.
//   clk, rst  : clock, asynchronous active-low reset
//   clr       : synchronous flush, wins over push and pop
//   i_push    : write request; dropped when full unless a pop happens too
//   i_row     : row to write
//   i_pop     : consumer accepts head; ignored when empty
//   o_head    : head row, or the last popped row while empty
//   o_count   : rows stored
//   o_full    : count == DEPTH
//   o_empty   : count == 0
// ----------------------------------------------------------------------------
module drain_fifo
    import tpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       i_push,
    input  row_t                       i_row,
    input  logic                       i_pop,
    output row_t                       o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    row_t             r_mem [DEPTH];
    row_t             r_last;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_pop;
    logic             w_do_push;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push
    // alongside a pop.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH on
    // their own. r_last keeps the most recently popped row so the head
    // output holds steady once the FIFO drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_row;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : r_last;
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/systolic_drain.sv
// ----------------------------------------------------------------------------
// systolic_drain
// Downstream neighbour of the 2x2 systolic array. It re-aligns the two
// bottom-row column outputs (column 2 lags column 1 by one cycle) into a
// single row, buffers rows in drain_fifo and offers them over valid/ready.
// The array cannot stall, so a row arriving at a full FIFO is dropped and
// flagged instead of back-pressured.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous flush of FIFO, pending column-1 value and flags
//   bus      : systolic_drain_if.slave (column inputs, row output, status)
// Optional: define SYSTOLIC_DRAIN_RELU_EN to clamp negative lanes to zero
// before they are stored. This adds no latency.
// ----------------------------------------------------------------------------
module systolic_drain
    import tpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    systolic_drain_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_hold;
    logic              r_pend;
    logic              r_overflow;
    logic              r_skew_err;

    logic              w_row_ok;
    logic              w_pair_err;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    row_t              w_row;
    row_t              w_head;

    // A row is complete when column 2 shows up exactly one cycle after
    // column 1. Either half arriving without its partner is a pairing fault.
    assign w_row_ok   = bus.in_valid_2 && r_pend;
    assign w_pair_err = bus.in_valid_2 != r_pend;

    // Full implies non-empty, so the only thing that can save the row is the
    // consumer taking the head in the same cycle.
    assign w_drop     = w_row_ok && w_full && !bus.out_ready;

`ifdef SYSTOLIC_DRAIN_RELU_EN
    assign w_row.lane1 = relu(r_hold);
    assign w_row.lane2 = relu(bus.in_data_2);
`else
    assign w_row.lane1 = r_hold;
    assign w_row.lane2 = bus.in_data_2;
`endif

    // Skew stage: column 1 is captured every cycle and waits one cycle for
    // its column-2 partner. The sticky flags latch faults until clr or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold     <= '0;
            r_pend     <= 1'b0;
            r_overflow <= 1'b0;
            r_skew_err <= 1'b0;
        end else begin
            r_hold <= bus.in_data_1;
            if (clr) begin
                r_pend     <= 1'b0;
                r_overflow <= 1'b0;
                r_skew_err <= 1'b0;
            end else begin
                r_pend     <= bus.in_valid_1;
                r_overflow <= r_overflow || w_drop;
                r_skew_err <= r_skew_err || w_pair_err;
            end
        end
    end

    drain_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .i_push  (w_row_ok),
        .i_row   (w_row),
        .i_pop   (bus.out_ready),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.out_data_1 = w_head.lane1;
    assign bus.out_data_2 = w_head.lane2;
    assign bus.out_valid  = !w_empty;
    assign bus.count      = w_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.overflow   = r_overflow;
    assign bus.skew_err   = r_skew_err;

endmodule

// File: tb/tb_systolic_drain.sv
// ----------------------------------------------------------------------------
// tb_systolic_drain
// Self-checking bench for systolic_drain. A table of hand-derived vectors
// covers single rows, ReLU and pairing faults; directed sequences cover
// fill/drain, overflow, clr and mid-stream reset; a randomized phase is
// checked against a queue-based reference model of the drain.
// ----------------------------------------------------------------------------
module tb_systolic_drain;

    localparam int DEPTH = 4;

`ifdef SYSTOLIC_DRAIN_RELU_EN
    localparam logic [15:0] R2L1 = 16'h0000;
`else
    localparam logic [15:0] R2L1 = 16'hFF00;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;

    systolic_drain_if #(.DEPTH(DEPTH)) bus ();

    systolic_drain #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model: a row queue plus the pending column-1 value and flags.
    logic [31:0] mq[$];
    logic [31:0] mLast;
    logic [15:0] mHold;
    logic        mPend;
    logic        mOvf;
    logic        mSkew;

    typedef struct packed {
        logic        v1;
        logic [15:0] d1;
        logic        v2;
        logic [15:0] d2;
        logic        rdy;
        logic        c;
        logic        eValid;
        logic [15:0] eD1;
        logic [15:0] eD2;
        logic [2:0]  eCount;
        logic        eFull;
        logic        eEmpty;
        logic        eOvf;
        logic        eSkew;
    } vec_t;

    vec_t tbl[11];

    // Negative Q8.8 values clamp to zero when the ReLU build is selected.
    function automatic logic [15:0] refLane(input logic [15:0] x);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        return ($signed(x) < 0) ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    task automatic modelReset();
        mq.delete();
        mLast = '0;
        mHold = '0;
        mPend = 1'b0;
        mOvf  = 1'b0;
        mSkew = 1'b0;
    endtask

    // Advances the model by one clock edge using the inputs of that cycle.
    task automatic modelStep(input logic v1, input logic [15:0] d1,
                             input logic v2, input logic [15:0] d2,
                             input logic rdy, input logic c);
        bit doPop;
        bit doPush;
        doPop  = 0;
        doPush = 0;
        if (c) begin
            mq.delete();
            mPend = 1'b0;
            mOvf  = 1'b0;
            mSkew = 1'b0;
        end else begin
            doPop = (mq.size() > 0) && rdy;
            if (v2 && mPend) begin
                if (mq.size() < DEPTH || doPop) doPush = 1;
                else                            mOvf = 1'b1;
            end
            if (v2 != mPend) mSkew = 1'b1;
            if (doPop)  mLast = mq.pop_front();
            if (doPush) mq.push_back({refLane(mHold), refLane(d2)});
            mPend = v1;
        end
        mHold = d1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs, steps the model at the edge and returns
    // 1 time unit after the edge with the DUT outputs settled.
    task automatic applyStimulus(input logic v1, input logic [15:0] d1,
                                 input logic v2, input logic [15:0] d2,
                                 input logic rdy, input logic c);
        bus.in_valid_1 = v1;
        bus.in_data_1  = d1;
        bus.in_valid_2 = v2;
        bus.in_data_2  = d2;
        bus.out_ready  = rdy;
        clr            = c;
        @(posedge clk);
        modelStep(v1, d1, v2, d2, rdy, c);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] head;
        head = (mq.size() != 0) ? mq[0] : mLast;
        check({tag, ".valid"}, bus.out_valid, mq.size() != 0);
        check({tag, ".data1"}, bus.out_data_1, head[31:16]);
        check({tag, ".data2"}, bus.out_data_2, head[15:0]);
        check({tag, ".count"}, bus.count, mq.size());
        check({tag, ".full"},  bus.full, mq.size() == DEPTH);
        check({tag, ".empty"}, bus.empty, mq.size() == 0);
        check({tag, ".ovf"},   bus.overflow, mOvf);
        check({tag, ".skew"},  bus.skew_err, mSkew);
    endtask

    // Streams n back-to-back rows {base+i, base+0x100+i}; column 2 of row i
    // shares a cycle with column 1 of row i+1.
    task automatic sendRows(input int n, input logic rdy,
                            input logic [15:0] base, input string tag);
        for (int i = 0; i <= n; i++) begin
            applyStimulus(i < n, base + 16'(i), i > 0,
                          base + 16'h0100 + 16'(i - 1), rdy, 1'b0);
            checkOutput($sformatf("%s%0d", tag, i));
        end
    endtask

    task automatic idle(input int n, input logic rdy, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, rdy, 1'b0);
            checkOutput($sformatf("%s%0d", tag, i));
        end
    endtask

    initial begin
        bus.in_valid_1 = 1'b0;
        bus.in_data_1  = '0;
        bus.in_valid_2 = 1'b0;
        bus.in_data_2  = '0;
        bus.out_ready  = 1'b0;
        modelReset();

        //                v1  d1       v2  d2       rdy clr  val d1       d2       cnt  f  e  o  s
        tbl[0]  = '{1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0200, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0200, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 16'hFF00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0200, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b1, R2L1,     16'h0080, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, R2L1,     16'h0080, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, R2L1,     16'h0080, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, R2L1,     16'h0080, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, R2L1,     16'h0080, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, R2L1,     16'h0080, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, R2L1,     16'h0080, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst = 1'b1;

        // Table-driven vectors: single row, ReLU row, pairing faults.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2,
                          tbl[i].rdy, tbl[i].c);
            check($sformatf("vec%0d.valid", i), bus.out_valid,  tbl[i].eValid);
            check($sformatf("vec%0d.data1", i), bus.out_data_1, tbl[i].eD1);
            check($sformatf("vec%0d.data2", i), bus.out_data_2, tbl[i].eD2);
            check($sformatf("vec%0d.count", i), bus.count,      tbl[i].eCount);
            check($sformatf("vec%0d.full", i),  bus.full,       tbl[i].eFull);
            check($sformatf("vec%0d.empty", i), bus.empty,      tbl[i].eEmpty);
            check($sformatf("vec%0d.ovf", i),   bus.overflow,   tbl[i].eOvf);
            check($sformatf("vec%0d.skew", i),  bus.skew_err,   tbl[i].eSkew);
        end

        // Fill with four back-to-back rows, then drain one per cycle.
        sendRows(4, 1'b0, 16'h1000, "fill");
        check("fill.full_const",  bus.full, 1'b1);
        check("fill.count_const", bus.count, 3'd4);
        check("fill.head_const",  bus.out_data_1, 16'h1000);
        idle(4, 1'b1, "drain");
        check("drain.empty_const", bus.empty, 1'b1);

        // Fifth row with no pop is dropped; stored rows stay intact.
        sendRows(4, 1'b0, 16'h2000, "ovfA");
        sendRows(1, 1'b0, 16'h3000, "ovfB");
        check("ovf.flag_const",  bus.overflow, 1'b1);
        check("ovf.count_const", bus.count, 3'd4);
        idle(4, 1'b1, "ovfDrain");
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("ovfClr");

        // Fifth row with a same-cycle pop is accepted, count stays at four.
        sendRows(4, 1'b0, 16'h4000, "popA");
        applyStimulus(1'b1, 16'h5000, 1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("popB0");
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h5100, 1'b1, 1'b0);
        checkOutput("popB1");
        check("pop.ovf_const",   bus.overflow, 1'b0);
        check("pop.count_const", bus.count, 3'd4);
        idle(4, 1'b1, "popDrain");
        check("pop.last_const", bus.out_data_1, 16'h5000);

        // clr with a concurrent push after a skew fault.
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h7777, 1'b0, 1'b0);
        checkOutput("clrA");
        applyStimulus(1'b1, 16'h6000, 1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("clrB");
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h6100, 1'b0, 1'b1);
        checkOutput("clrC");
        check("clr.empty_const", bus.empty, 1'b1);
        check("clr.skew_const",  bus.skew_err, 1'b0);

        // Asynchronous reset with three rows stored.
        sendRows(3, 1'b0, 16'h8000, "rstFill");
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("rstMid");
        check("rstMid.count_const", bus.count, 3'd0);
        check("rstMid.data_const",  bus.out_data_1, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Randomized traffic: mostly well-paired rows with occasional faults,
        // random back-pressure and the odd flush.
        begin
            logic prevV1;
            prevV1 = 1'b0;
            for (int i = 0; i < 400; i++) begin
                logic v1;
                logic v2;
                v1 = ($urandom_range(0, 3) != 0);
                v2 = prevV1 ^ ($urandom_range(0, 19) == 0);
                applyStimulus(v1, 16'($urandom), v2, 16'($urandom),
                              1'($urandom_range(0, 1)),
                              $urandom_range(0, 39) == 0);
                checkOutput($sformatf("rand%0d", i));
                prevV1 = v1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Downstream neighbour of the 2x2 systolic array.
- Consumes the two bottom-row column outputs (psum plus valid). Column 2 lags column 1 by exactly one cycle for the same result row.
- Deskews each result row into one aligned 2-lane word and buffers it in a small FIFO.
- Presents rows to the next stage over a valid/ready handshake. The array cannot stall, so overflow is flagged, not back-pressured.

Parameters:
- DATA_W, 16: lane width (Q8.8 signed fixed point).
- DEPTH, 4: FIFO depth in rows; power of two, >= 2.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush: empties FIFO, clears pending and sticky flags
- in_data_1  in  DATA_W  column-1 psum from array
- in_valid_1  in  1  column-1 valid
- in_data_2  in  DATA_W  column-2 psum from array
- in_valid_2  in  1  column-2 valid
- out_data_1  out  DATA_W  head row, lane 1
- out_data_2  out  DATA_W  head row, lane 2
- out_valid  out  1  head row present
- out_ready  in  1  consumer accepts head
- count  out  $clog2(DEPTH+1)  rows stored
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: a row was dropped because the FIFO was full
- skew_err  out  1  sticky: column pairing violated

Behaviour:
- Reset (rst low, asynchronous): FIFO pointers = 0, count = 0, pend = 0. Outputs: out_data_* = 0, out_valid = 0, empty = 1, full = 0, overflow = 0, skew_err = 0.
- Reset mid-stream discards all stored and pending rows.
- Skew stage:
  - Every cycle: hold_q <= in_data_1 and pend <= in_valid_1.
  - A row forms in cycle t when in_valid_2 = 1 and pend = 1: {hold_q, in_data_2}. This produces a write request.
- Pairing violations (row dropped, skew_err set):
  - in_valid_2 = 1 with pend = 0.
  - pend = 1 with in_valid_2 = 0, i.e. an orphaned column-1 value.
- Back-to-back rows are legal every cycle: column-1 row k+1 arrives in the same cycle as column-2 row k.
- FIFO:
  - Write at the end of the pairing cycle.
  - out_valid rises the cycle after the write, giving 2 cycles of latency from in_valid_1 of a row to out_valid.
  - No bypass when empty.
  - Pop when out_valid && out_ready.
  - Head data comes from registered/array storage. out_data_* hold the last head value when empty.
- Full:
  - A write with a same-cycle pop succeeds, and count is unchanged.
  - A write without a pop is dropped, stored data is unchanged, and overflow is set.
- Empty: out_ready is ignored and count never underflows.
- Simultaneous push and pop at any level: count unchanged, pointers both advance.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- clr:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: empty = 1, count = 0, pend = 0, overflow = 0, skew_err = 0.
- Arithmetic: none in the base configuration; data passes bit-exact.

Optional Feature:
- Macro SYSTOLIC_DRAIN_RELU_EN.
- Defined: each lane is passed through ReLU (negative, MSB = 1 -> 0) before the FIFO write. This adds no latency.
- Undefined: lanes are stored bit-exact, and no ReLU logic is instantiated.

Decomposition:
- Shared package tpu_pkg:
  - DATA_W constant (16).
  - typedef row_t: packed struct {lane1, lane2} of DATA_W each.
  - relu function, used under the macro.
- One sub-module: drain_fifo, a parameterised row_t FIFO with push/pop/clr, count, full and empty.
- The skew stage, sticky flags and ReLU stay in the top module.

Test Plan:
- Single row: in_valid_1 = 1 with 0x0100 at t; in_valid_2 = 1 with 0x0200 at t+1 -> out_valid at t+2 with {0x0100, 0x0200}, count = 1, skew_err = 0.
- Streaming 4 rows back-to-back with out_ready = 0 -> full = 1, count = 4. Then out_ready = 1 -> rows pop in order, one per cycle, and empty = 1 after the 4th.
- Fill to 4 with out_ready = 0, then send a 5th row -> overflow = 1, stored rows unchanged. Repeat with out_ready = 1 on the write cycle -> no overflow, count stays 4.
- Pairing faults: in_valid_2 alone -> skew_err = 1, no write. After clr, in_valid_1 alone followed by idle -> skew_err = 1.
- Reset and clr mid-stream: rst low with 3 rows stored -> all outputs at reset values immediately. clr with a concurrent push -> empty next cycle, overflow/skew_err = 0.
- With SYSTOLIC_DRAIN_RELU_EN: row {0xFF00, 0x0080} -> out {0x0000, 0x0080}. Without the macro -> out {0xFF00, 0x0080}.
